// File: rtl/marmot_wb_ctrl.sv
// rtl/marmot_wb_ctrl.sv - Wishbone control block for the Marmot core
//
// Purpose: Wishbone slave on the Caravel management bus that sequences the
// core reset release through a programmable hold counter, lets firmware
// override user IO outputs/output-enables per bit, and exposes scratch and
// status registers for bring-up.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   wbs_stb_i .. wbs_dat_i   Wishbone slave request (strobe, cycle, we, sel, addr, data)
//   wbs_ack_o, wbs_dat_o     Wishbone acknowledge and registered read data
//   core_io_out_i/oeb_i      pad outputs / output enables driven by the core
//   io_out_o, io_oeb_o       muxed pad outputs / output enables
//   core_rst_n_o             registered active-low reset to the core
//   irq_o                    run-done interrupt level
//
// Optional feature macro: MARMOT_WB_CTRL_IRQ_EN (adds CTRL bit2 IRQ_MASK and
// drives irq_o = RUN_DONE & IRQ_MASK; otherwise irq_o is tied low).

module marmot_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_IO      = 38,
  parameter logic [15:0] RST_CNT_RST = 16'd16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] core_io_out_i,
  input  logic [NUM_IO-1:0] core_io_oeb_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oeb_o,
  output logic              core_rst_n_o,
  output logic              irq_o
);

  localparam int HI_W = NUM_IO - 32;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [15:0]       rst_cnt;
  logic              run;
  logic              ovr_en;
  logic              run_done;
  logic [31:0]       scratch;
  logic [31:0]       out_lo;
  logic [31:0]       oeb_lo;
  logic [HI_W-1:0]   out_hi;
  logic [HI_W-1:0]   oeb_hi;
  logic              hit;
  logic              req;
  logic              wr;
  logic              rd;
  logic              done_clr;
  logic              ctrl_mask_rd;
  logic [31:0]       wmask;
  logic [31:0]       rdata;

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] val,
                                          input logic [31:0] m);
    return (old & ~m) | (val & m);
  endfunction

  assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A request already acked this cycle is not accepted again, so a held
  // strobe yields one ack every other cycle.
  assign req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
  assign wr    = req & wbs_we_i;
  assign rd    = req & ~wbs_we_i;
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign done_clr = wr & (wbs_adr_i[7:0] == 8'h04) & wbs_sel_i[0] & wbs_dat_i[2];

`ifdef MARMOT_WB_CTRL_IRQ_EN
  logic irq_mask;
  assign ctrl_mask_rd = irq_mask;
  assign irq_o        = run_done & irq_mask;
`else
  assign ctrl_mask_rd = 1'b0;
  assign irq_o        = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (wbs_adr_i[7:0])
      8'h00: rdata = {29'h0, ctrl_mask_rd, ovr_en, run};
      8'h04: rdata = {cnt, 13'h0, run_done, state};
      8'h08: rdata = {16'h0, rst_cnt};
      8'h0C: rdata = scratch;
      8'h10: rdata = out_lo;
      8'h14: rdata = 32'(out_hi);
      8'h18: rdata = oeb_lo;
      8'h1C: rdata = 32'(oeb_hi);
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      run       <= 1'b0;
      ovr_en    <= 1'b0;
      rst_cnt   <= RST_CNT_RST;
      scratch   <= 32'h0;
      out_lo    <= 32'h0;
      oeb_lo    <= 32'h0;
      out_hi    <= '0;
      oeb_hi    <= '0;
`ifdef MARMOT_WB_CTRL_IRQ_EN
      irq_mask  <= 1'b0;
`endif
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : 32'h0;
      if (wr) begin
        case (wbs_adr_i[7:0])
          8'h00: if (wbs_sel_i[0]) begin
            run    <= wbs_dat_i[0];
            ovr_en <= wbs_dat_i[1];
`ifdef MARMOT_WB_CTRL_IRQ_EN
            irq_mask <= wbs_dat_i[2];
`endif
          end
          8'h08: rst_cnt <= (rst_cnt & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
          8'h0C: scratch <= merge32(scratch, wbs_dat_i, wmask);
          8'h10: out_lo  <= merge32(out_lo, wbs_dat_i, wmask);
          8'h14: out_hi  <= (out_hi & ~wmask[HI_W-1:0]) | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
          8'h18: oeb_lo  <= merge32(oeb_lo, wbs_dat_i, wmask);
          8'h1C: oeb_hi  <= (oeb_hi & ~wmask[HI_W-1:0]) | (wbs_dat_i[HI_W-1:0] & wmask[HI_W-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Reset sequencer. The live counter is loaded only on HOLD->COUNT, so
  // rewriting RST_CNT mid-count leaves the running countdown alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_HOLD;
      cnt          <= 16'h0;
      run_done     <= 1'b0;
      core_rst_n_o <= 1'b0;
    end else begin
      if (done_clr) run_done <= 1'b0;
      if (!run) begin
        state        <= ST_HOLD;
        core_rst_n_o <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            cnt   <= rst_cnt;
            state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (cnt == 16'h0) begin
              state        <= ST_RUN;
              run_done     <= 1'b1;
              core_rst_n_o <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          ST_RUN:  core_rst_n_o <= 1'b1;
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

  assign io_out_o = ovr_en ? {out_hi, out_lo} : core_io_out_i;
  assign io_oeb_o = ovr_en ? {oeb_hi, oeb_lo} : core_io_oeb_i;

endmodule

// File: tb/tb_marmot_wb_ctrl.sv
// tb/tb_marmot_wb_ctrl.sv - directed self-checking bench for marmot_wb_ctrl

module tb_marmot_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] core_out;
  logic [37:0] core_oeb;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic        core_rst_n;
  logic        irq;

  int checks;
  int errors;

  marmot_wb_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .core_io_out_i (core_out),
    .core_io_oeb_i (core_oeb),
    .io_out_o      (io_out),
    .io_oeb_o      (io_oeb),
    .core_rst_n_o  (core_rst_n),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One idle cycle first so the previous ack has dropped; returns #1 after
  // the ack edge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    int lat;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 8);
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check_eq("ack_latency", 64'(lat), 64'd1);
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_xfer(1'b1, BASE | 32'(off), d, s, q);
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] q);
    wb_xfer(1'b0, BASE | 32'(off), 32'h0, 4'hF, q);
  endtask

  task automatic hold_req(input logic [31:0] a, output int acks);
    acks = 0;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
      if (i == 1) check_eq("dat_zero_no_ack", 64'(rdat), 64'h0);
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  initial begin
    logic [31:0] q;
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0;
    core_out = 38'h0A_1234_5678;
    core_oeb = 38'h35_8765_4321;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 64'(ack), 64'h0);
    check_eq("rst_dat", 64'(rdat), 64'h0);
    check_eq("rst_core_rst_n", 64'(core_rst_n), 64'h0);
    check_eq("rst_irq", 64'(irq), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_rd(8'h04, q); check_eq("rst_status", 64'(q), 64'h0);
    wb_rd(8'h08, q); check_eq("rst_rst_cnt", 64'(q), 64'h10);

    // Release sequence: RST_CNT=5 -> core out of reset 7 cycles after ack.
    wb_wr(8'h08, 32'd5, 4'hF);
    wb_wr(8'h00, 32'h1, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    check_eq("seq_still_reset", 64'(core_rst_n), 64'h0);
    @(posedge clk);
    #1;
    check_eq("seq_released", 64'(core_rst_n), 64'h1);
    wb_rd(8'h04, q); check_eq("seq_status", 64'(q), 64'h6);

    // Stop, clear RUN_DONE, then abort a long count midway.
    wb_wr(8'h00, 32'h0, 4'hF);
    wb_wr(8'h04, 32'h4, 4'hF);
    wb_rd(8'h04, q); check_eq("status_cleared", 64'(q), 64'h0);
    wb_wr(8'h08, 32'd100, 4'hF);
    wb_wr(8'h00, 32'h1, 4'hF);
    repeat (20) @(posedge clk);
    wb_rd(8'h04, q); check_eq("status_counting", 64'(q & 32'h7), 64'h1);
    wb_wr(8'h08, 32'd3, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rewrite_no_effect", 64'(core_rst_n), 64'h0);
    wb_wr(8'h00, 32'h0, 4'hF);
    @(posedge clk);
    wb_rd(8'h04, q); check_eq("abort_status", 64'(q & 32'h7), 64'h0);
    check_eq("abort_core_rst_n", 64'(core_rst_n), 64'h0);

    // Byte-select writes.
    wb_wr(8'h0C, 32'hA5A5_A5A5, 4'hF);
    wb_wr(8'h0C, 32'hFFFF_FFFF, 4'b0010);
    wb_rd(8'h0C, q); check_eq("scratch_bytesel", 64'(q), 64'hA5A5_FFA5);

    // IO override.
    wb_wr(8'h10, 32'h1, 4'hF);
    wb_wr(8'h18, 32'hFFFF_FFFE, 4'hF);
    wb_wr(8'h14, 32'hFFFF_FFFF, 4'hF);
    wb_wr(8'h1C, 32'h15, 4'hF);
    wb_rd(8'h14, q); check_eq("out_hi_width", 64'(q), 64'h3F);
    check_eq("io_out_pass0", 64'(io_out), 64'h0A_1234_5678);
    wb_wr(8'h00, 32'h2, 4'hF);
    check_eq("io_out_ovr", 64'(io_out), 64'h3F_0000_0001);
    check_eq("io_oeb_ovr", 64'(io_oeb), 64'h15_FFFF_FFFE);
    wb_wr(8'h00, 32'h0, 4'hF);
    check_eq("io_out_pass", 64'(io_out), 64'h0A_1234_5678);
    check_eq("io_oeb_pass", 64'(io_oeb), 64'h35_8765_4321);

    // Address miss, unmapped offset, held request.
    hold_req(BASE + 32'h100, n); check_eq("miss_no_ack", 64'(n), 64'h0);
    wb_rd(8'h20, q); check_eq("unmapped_read", 64'(q), 64'h0);
    wb_wr(8'h20, 32'hDEAD_BEEF, 4'hF);
    wb_rd(8'h0C, q); check_eq("unmapped_write_ignored", 64'(q), 64'hA5A5_FFA5);
    hold_req(BASE + 32'h0C, n); check_eq("held_two_acks", 64'(n), 64'h2);

    // IRQ / RST_CNT=0 boundary.
    wb_wr(8'h08, 32'd0, 4'hF);
    wb_wr(8'h00, 32'h5, 4'hF);
    @(posedge clk);
    #1;
    check_eq("irq_cycle1", 64'(irq), 64'h0);
    @(posedge clk);
    #1;
`ifdef MARMOT_WB_CTRL_IRQ_EN
    check_eq("irq_cycle2", 64'(irq), 64'h1);
    wb_rd(8'h00, q); check_eq("ctrl_mask", 64'(q), 64'h5);
`else
    check_eq("irq_cycle2", 64'(irq), 64'h0);
    wb_rd(8'h00, q); check_eq("ctrl_mask", 64'(q), 64'h1);
`endif
    check_eq("cnt0_released", 64'(core_rst_n), 64'h1);
    wb_wr(8'h04, 32'h4, 4'hF);
    check_eq("irq_cleared", 64'(irq), 64'h0);
    wb_rd(8'h04, q); check_eq("status_run_nodone", 64'(q), 64'h2);

    // Reset mid-sequence.
    wb_wr(8'h00, 32'h0, 4'hF);
    wb_wr(8'h08, 32'd50, 4'hF);
    wb_wr(8'h00, 32'h1, 4'hF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_core_rst_n", 64'(core_rst_n), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_rd(8'h00, q); check_eq("midrst_ctrl", 64'(q), 64'h0);
    wb_rd(8'h04, q); check_eq("midrst_status", 64'(q), 64'h0);
    wb_rd(8'h08, q); check_eq("midrst_rst_cnt", 64'(q), 64'h10);
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_stays_reset", 64'(core_rst_n), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/marmot_wb_ctrl.md
Name: marmot_wb_ctrl

Overview:
- Wishbone slave control block between the Caravel management bus and the Marmot core.
- Sequences the core reset release through a programmable hold counter.
- Lets firmware override the user IO output and output-enable pads per bit.
- Provides a scratch register and a read-only status register for bring-up.

Parameters:
- BASE_ADDR, 32'h3000_0000: slave base; decode when wbs_adr_i[31:8] == BASE_ADDR[31:8].
- NUM_IO, 38: number of user IO pads handled (range 33..64).
- RST_CNT_RST, 16'd16: reset value of the RST_CNT register.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous reset, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_io_out_i  in  NUM_IO  core-driven pad outputs.
- core_io_oeb_i  in  NUM_IO  core-driven pad output enables, active-low.
- io_out_o  out  NUM_IO  muxed pad outputs.
- io_oeb_o  out  NUM_IO  muxed pad output enables.
- core_rst_n_o  out  1  reset to the core, active-low.
- irq_o  out  1  interrupt; see Optional Feature.

Behaviour:

Reset values (rst_n=0 sampled at a clk edge):
- wbs_ack_o=0, wbs_dat_o=0, core_rst_n_o=0, irq_o=0.
- FSM=HOLD; all registers 0 except RST_CNT=RST_CNT_RST.
- rst_n has priority over any bus access in the same cycle.
- Reset mid-sequence returns the FSM to HOLD and the core to reset.

Bus handshake:
- wbs_ack_o=1 for exactly one cycle, in the cycle after a cycle with stb&cyc&~ack and an address hit.
- Latency is 1; no back-to-back double ack. A request held across the ack cycle is acked only once, then re-acked the following cycle if still asserted.
- Writes take effect at the clk edge where ack rises. Only bytes with wbs_sel_i set are written.
- Read data is registered and valid with ack; wbs_dat_o=0 when ack=0.
- Address miss: no ack.
- Hit on an unmapped offset: ack, read returns 0, write is ignored.

Register map (word offsets):
- 0x00 CTRL rw: bit0 RUN, bit1 IO_OVR_EN.
- 0x04 STATUS ro: [1:0] FSM state (HOLD=0, COUNT=1, RUN=2), bit2 RUN_DONE sticky (write 1 to clear), [31:16] live counter.
- 0x08 RST_CNT rw [15:0].
- 0x0C SCRATCH rw [31:0].
- 0x10 OUT_OVR_LO [31:0]; 0x14 OUT_OVR_HI [NUM_IO-33:0].
- 0x18 OEB_OVR_LO [31:0]; 0x1C OEB_OVR_HI [NUM_IO-33:0].

Reset sequencer FSM:
- HOLD: core_rst_n_o=0. When RUN=1, load cnt=RST_CNT and go to COUNT.
- COUNT: core_rst_n_o=0; cnt decrements by 1 per cycle. At cnt==0, go to RUN and set RUN_DONE.
  - RST_CNT=0 gives a single COUNT cycle.
  - Total release delay from the CTRL write ack is RST_CNT+2 cycles.
- RUN: core_rst_n_o=1 (registered).
- From any state, RUN=0 returns to HOLD on the next edge; this also holds mid-COUNT.
- Writing RST_CNT while in COUNT does not affect the live counter.
- Counter is 16-bit; no wrap below 0.

IO mux (combinational):
- io_out_o = IO_OVR_EN ? OUT_OVR : core_io_out_i.
- io_oeb_o = IO_OVR_EN ? OEB_OVR : core_io_oeb_i.
- The OEB override reset value is 0, so firmware must program OEB_OVR before setting IO_OVR_EN.

Optional Feature:
- Macro: MARMOT_WB_CTRL_IRQ_EN.
- Defined: irq_o is a level equal to RUN_DONE & CTRL bit2 (IRQ_MASK, rw). It clears when RUN_DONE is cleared via STATUS write-1.
- Not defined: irq_o tied to 0, CTRL bit2 reads 0, and the STATUS bit2 clear remains functional.

Test Plan:
- After reset: read STATUS -> 0x0000_0000; read RST_CNT -> 0x0000_0010; core_rst_n_o=0; each read acked exactly 1 cycle after stb.
- Write RST_CNT=5, then CTRL=1 -> core_rst_n_o rises exactly 7 cycles after the write ack; STATUS reads 0x0000_0006 (RUN, RUN_DONE).
- Write RST_CNT=100, CTRL=1, then after 20 cycles CTRL=0 -> FSM HOLD, core_rst_n_o stays 0, RUN_DONE stays 0.
- Write SCRATCH=0xA5A5A5A5, then write 0xFFFF_FFFF with sel=4'b0010 -> read 0xA5A5FFA5.
- Program OUT_OVR_LO=0x1, OEB_OVR_LO=0xFFFF_FFFE, set CTRL=2 -> io_out_o[0]=1, io_oeb_o[0]=0, other bits take override values; clear CTRL -> core_io_out_i/core_io_oeb_i pass through.
- With MARMOT_WB_CTRL_IRQ_EN: CTRL=5, RST_CNT=0 -> irq_o=1 two cycles after the ack; write STATUS=4 -> irq_o=0. Without the macro, irq_o stays 0.
